// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and hazard helpers for the pipeline sequencer
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_t;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2,
    input logic [4:0] rd_ex,
    input logic       read_mem_ex
  );
    return read_mem_ex && (rd_ex != 5'd0) &&
           ((uses_rs1 && (rs1 == rd_ex)) || (uses_rs2 && (rs2 == rd_ex)));
  endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// rtl/hazard_controller_sat_counter.sv - saturating event counter, sticks at all-ones
module hazard_controller_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush sequencer with memory-wait timeout fault
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             rs1Address_ID,
  input  logic [4:0]             rs2Address_ID,
  input  logic                   usesRs1_ID,
  input  logic                   usesRs2_ID,
  input  logic [4:0]             rdAddress_EX,
  input  logic                   readMemory_EX,
  input  logic                   branchTaken_MEM,
  input  logic                   memRequest_MEM,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   ifidWrite,
  output logic                   ifidClear,
  output logic                   idexWrite,
  output logic                   idexClear,
  output logic                   exmemHold,
  output logic                   exmemClear,
  output logic                   memwbClear,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] stallCount,
  output logic [COUNT_WIDTH-1:0] flushCount
);

  localparam int WW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0] WC_ONE   = WW'(1);
  localparam logic [WW-1:0] WC_LIMIT = WW'(WAIT_TIMEOUT);

  ctrl_state_t   state_q, state_d;
  logic [WW-1:0] wait_count_q, wait_count_d;
  logic          load_use_w;
  logic          hold_now;
  logic          stall_inc;
  logic          flush_inc;

  always_comb begin
    load_use_w = load_use(rs1Address_ID, rs2Address_ID, usesRs1_ID, usesRs2_ID,
                          rdAddress_EX, readMemory_EX);

    case (state_q)
      RUN:      hold_now = memRequest_MEM & ~memReady;
      MEM_WAIT: hold_now = ~memReady;
      default:  hold_now = 1'b1;
    endcase

    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexWrite  = 1'b1;
    exmemHold  = 1'b0;
    ifidClear  = 1'b0;
    idexClear  = 1'b0;
    exmemClear = 1'b0;
    memwbClear = 1'b0;
    fault      = 1'b0;
    flush_inc  = 1'b0;

    // The memory wait outranks a branch: the branch is still sitting in MEM and is honoured on release.
    if (!reset) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      idexWrite = 1'b0;
      exmemHold = 1'b1;
    end else if (hold_now) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemHold  = 1'b1;
      memwbClear = 1'b1;
      fault      = (state_q == FAULT);
    end else if (branchTaken_MEM) begin
      ifidClear  = 1'b1;
      idexClear  = 1'b1;
      exmemClear = 1'b1;
      flush_inc  = 1'b1;
    end else if (load_use_w) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      idexClear = 1'b1;
    end

    stall_inc = reset & (state_q != FAULT) & ~pcWrite;

    state_d      = state_q;
    wait_count_d = wait_count_q;
    case (state_q)
      RUN: begin
        if (hold_now) begin
          state_d      = MEM_WAIT;
          wait_count_d = WC_ONE;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          state_d      = RUN;
          wait_count_d = '0;
        end else begin
          if (wait_count_q != {WW{1'b1}}) begin
            wait_count_d = wait_count_q + WC_ONE;
          end
          if ((WAIT_TIMEOUT != 0) && (wait_count_q == WC_LIMIT)) begin
            state_d = FAULT;
          end
        end
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      wait_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_count_q <= wait_count_d;
    end
  end

  hazard_controller_sat_counter #(.W(COUNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (stall_inc),
    .count (stallCount)
  );

  hazard_controller_sat_counter #(.W(COUNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (flush_inc),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for two hazard_controller configurations
module tb_hazard_controller;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_pair_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rdex = '0;
  logic       u1 = 1'b0, u2 = 1'b0, rmex = 1'b0, br = 1'b0, mreq = 1'b0, mrdy = 1'b0;

  logic        a_pc, a_ifw, a_ifc, a_idw, a_idc, a_hold, a_exc, a_mwc, a_fault;
  logic [31:0] a_stall, a_flush;
  logic        b_pc, b_ifw, b_ifc, b_idw, b_idc, b_hold, b_exc, b_mwc, b_fault;
  logic [3:0]  b_stall, b_flush;

  int checks = 0;
  int failures = 0;
  exp_pair_t sb[$];

  // Reference state per instance: 0 = defaults (timeout 16, 32-bit), 1 = timeout 4, 4-bit.
  int     m_timeout[2] = '{16, 4};
  int     m_width[2]   = '{32, 4};
  bit     m_waiting[2];
  bit     m_faulted[2];
  int     m_waited[2];
  longint m_stall[2];
  longint m_flush[2];

  always #5 clk = ~clk;

  hazard_controller dut_a (
    .clk(clk), .reset(reset),
    .rs1Address_ID(rs1), .rs2Address_ID(rs2), .usesRs1_ID(u1), .usesRs2_ID(u2),
    .rdAddress_EX(rdex), .readMemory_EX(rmex), .branchTaken_MEM(br),
    .memRequest_MEM(mreq), .memReady(mrdy),
    .pcWrite(a_pc), .ifidWrite(a_ifw), .ifidClear(a_ifc), .idexWrite(a_idw),
    .idexClear(a_idc), .exmemHold(a_hold), .exmemClear(a_exc), .memwbClear(a_mwc),
    .fault(a_fault), .stallCount(a_stall), .flushCount(a_flush)
  );

  hazard_controller #(.WAIT_TIMEOUT(4), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .rs1Address_ID(rs1), .rs2Address_ID(rs2), .usesRs1_ID(u1), .usesRs2_ID(u2),
    .rdAddress_EX(rdex), .readMemory_EX(rmex), .branchTaken_MEM(br),
    .memRequest_MEM(mreq), .memReady(mrdy),
    .pcWrite(b_pc), .ifidWrite(b_ifw), .ifidClear(b_ifc), .idexWrite(b_idw),
    .idexClear(b_idc), .exmemHold(b_hold), .exmemClear(b_exc), .memwbClear(b_mwc),
    .fault(b_fault), .stallCount(b_stall), .flushCount(b_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic longint sat_inc(input longint v, input int w);
    longint top = (64'sd1 <<< w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  // Outputs for this cycle from the pipeline rules, then advance the reference for the next edge.
  task automatic model_step(input int k, output obs_t o);
    bit pcw = 1, ifw = 1, idw = 1, hold = 0, ifc = 0, idc = 0, exc = 0, mwc = 0, flt = 0;
    bit lu;
    if (!reset) begin
      m_waiting[k] = 0; m_faulted[k] = 0; m_waited[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
      o.ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      o.stall = 0; o.flush = 0;
      return;
    end
    o.stall = 32'(m_stall[k]);
    o.flush = 32'(m_flush[k]);
    lu = rmex && rdex != 0 && ((u1 && rs1 == rdex) || (u2 && rs2 == rdex));
    if (m_faulted[k]) begin
      pcw = 0; ifw = 0; idw = 0; hold = 1; mwc = 1; flt = 1;
    end else if ((m_waiting[k] || mreq) && !mrdy) begin
      pcw = 0; ifw = 0; idw = 0; hold = 1; mwc = 1;
      m_stall[k] = sat_inc(m_stall[k], m_width[k]);
      if (!m_waiting[k]) begin
        m_waiting[k] = 1;
        m_waited[k] = 1;
      end else begin
        if (m_timeout[k] != 0 && m_waited[k] == m_timeout[k]) begin
          m_faulted[k] = 1;
          m_waiting[k] = 0;
        end
        m_waited[k]++;
      end
    end else begin
      m_waiting[k] = 0;
      m_waited[k] = 0;
      if (br) begin
        ifc = 1; idc = 1; exc = 1;
        m_flush[k] = sat_inc(m_flush[k], m_width[k]);
      end else if (lu) begin
        pcw = 0; ifw = 0; idc = 1;
        m_stall[k] = sat_inc(m_stall[k], m_width[k]);
      end
    end
    o.ctrl = {pcw, ifw, ifc, idw, idc, hold, exc, mwc, flt};
  endtask

  task automatic drive(input bit r, input logic [4:0] s1, input logic [4:0] s2, input bit e1,
                       input bit e2, input logic [4:0] rd, input bit ld, input bit b,
                       input bit mq, input bit mr);
    exp_pair_t e;
    @(posedge clk);
    #1;
    reset = r; rs1 = s1; rs2 = s2; u1 = e1; u2 = e2; rdex = rd; rmex = ld;
    br = b; mreq = mq; mrdy = mr;
    model_step(0, e.a);
    model_step(1, e.b);
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_pair_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("a_ctrl",  {23'd0, a_pc, a_ifw, a_ifc, a_idw, a_idc, a_hold, a_exc, a_mwc, a_fault},
              {23'd0, e.a.ctrl});
        check("a_stall", a_stall, e.a.stall);
        check("a_flush", a_flush, e.a.flush);
        check("b_ctrl",  {23'd0, b_pc, b_ifw, b_ifc, b_idw, b_idc, b_hold, b_exc, b_mwc, b_fault},
              {23'd0, e.b.ctrl});
        check("b_stall", {28'd0, b_stall}, e.b.stall);
        check("b_flush", {28'd0, b_flush}, e.b.flush);
      end
    end
  end

  initial begin : stimulus
    bit slow = 0;
    do_reset();
    idle();
    drive(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    idle();
    drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    idle();
    do_reset();
    drive(1, 5, 5, 1, 1, 5, 1, 1, 0, 0);
    idle();
    do_reset();
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle();
    do_reset();
    repeat (8) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    do_reset();
    idle();
    repeat (20) begin
      drive(1, 0, 7, 0, 1, 7, 1, 0, 0, 0);
      idle();
    end
    @(negedge clk);
    #1;
    check("sat_stall_15", {28'd0, b_stall}, 32'd15);
    check("stall_20", a_stall, 32'd20);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) slow = ~slow;
      drive($urandom_range(0, 99) != 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
            slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0));
    end
    idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
